// File: rtl/bp_cfg_boot_seq.sv
// Boot sequencer for the tile config endpoint: writes freeze, cache/CCE modes and CCE
// microcode over the uncached command port, then passes the port through to the host.
module bp_cfg_boot_seq
  #(parameter int paddr_width_p     = 40
   ,parameter int cce_pc_width_p    = 8
   ,parameter int cce_instr_width_p = 64
   ,parameter int cfg_addr_width_p  = 16
   ,parameter int cfg_data_width_p  = 64
   ,parameter int dword_width_p     = 64
   ,localparam int xce_mem_msg_width_lp = dword_width_p + paddr_width_p + 7
   )
  (input  logic                            clk_i
   ,input  logic                            reset_i
   ,input  logic                            start_i
   ,input  logic [paddr_width_p-1:0]        cfg_base_addr_i
   ,input  logic [cfg_data_width_p-1:0]     icache_mode_i
   ,input  logic [cfg_data_width_p-1:0]     dcache_mode_i
   ,input  logic [cfg_data_width_p-1:0]     cce_mode_i
   ,input  logic [cce_pc_width_p:0]         ucode_len_i
   ,output logic                            rom_v_o
   ,output logic [cce_pc_width_p-1:0]       rom_addr_o
   ,input  logic [cce_instr_width_p-1:0]    rom_data_i
   ,output logic [xce_mem_msg_width_lp-1:0] cfg_cmd_o
   ,output logic                            cfg_cmd_v_o
   ,input  logic                            cfg_cmd_ready_i
   ,input  logic [xce_mem_msg_width_lp-1:0] cfg_resp_i
   ,input  logic                            cfg_resp_v_i
   ,output logic                            cfg_resp_yumi_o
   ,input  logic [xce_mem_msg_width_lp-1:0] host_cmd_i
   ,input  logic                            host_cmd_v_i
   ,output logic                            host_cmd_ready_o
   ,output logic [xce_mem_msg_width_lp-1:0] host_resp_o
   ,output logic                            host_resp_v_o
   ,input  logic                            host_resp_yumi_i
   ,output logic                            done_o
   );

   localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp = cfg_addr_width_p'('h0008);
   localparam logic [cfg_addr_width_p-1:0] icache_addr_lp = cfg_addr_width_p'('h0024);
   localparam logic [cfg_addr_width_p-1:0] dcache_addr_lp = cfg_addr_width_p'('h002c);
   localparam logic [cfg_addr_width_p-1:0] cce_addr_lp    = cfg_addr_width_p'('h0034);
   localparam logic [cfg_addr_width_p-1:0] ucode_base_lp  = cfg_addr_width_p'('h8000);
   localparam logic [3:0] uc_wr_lp   = 4'b0011;
   localparam logic [2:0] size_8_lp  = 3'b011;

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_ROM, S_RDATA, S_DONE} state_e;
   typedef enum logic [2:0] {STEP_FREEZE, STEP_ICACHE, STEP_DCACHE, STEP_CCE,
                             STEP_UCODE, STEP_UNFREEZE} step_e;

   state_e                        state_r;
   step_e                         step_r;
   logic [cce_pc_width_p:0]       pc_r;
   logic [cce_pc_width_p:0]       len_r;
   logic [cce_instr_width_p-1:0]  data_r;
   logic [cfg_data_width_p-1:0]   icache_mode_r;
   logic [cfg_data_width_p-1:0]   dcache_mode_r;
   logic [cfg_data_width_p-1:0]   cce_mode_r;
   logic                          done_r;

   logic [cce_pc_width_p:0]       pc_inc;
   logic [cfg_addr_width_p-1:0]   cfg_addr;
   logic [dword_width_p-1:0]      blk_data;
   logic [xce_mem_msg_width_lp-1:0] boot_cmd;

   assign pc_inc = pc_r + (cce_pc_width_p+1)'(1);
   assign done_o = done_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r       <= S_IDLE;
         step_r        <= STEP_FREEZE;
         pc_r          <= '0;
         len_r         <= '0;
         data_r        <= '0;
         icache_mode_r <= '0;
         dcache_mode_r <= '0;
         cce_mode_r    <= '0;
         done_r        <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: if (start_i) begin
               icache_mode_r <= icache_mode_i;
               dcache_mode_r <= dcache_mode_i;
               cce_mode_r    <= cce_mode_i;
               len_r         <= ucode_len_i;
               pc_r          <= '0;
               step_r        <= STEP_FREEZE;
               state_r       <= S_SEND;
            end
            S_SEND: if (cfg_cmd_ready_i) state_r <= S_WAIT;
            S_WAIT: if (cfg_resp_v_i) begin
               case (step_r)
                  STEP_FREEZE: begin step_r <= STEP_ICACHE; state_r <= S_SEND; end
                  STEP_ICACHE: begin step_r <= STEP_DCACHE; state_r <= S_SEND; end
                  STEP_DCACHE: begin step_r <= STEP_CCE;    state_r <= S_SEND; end
                  STEP_CCE: begin
                     if (len_r != '0) begin
                        step_r  <= STEP_UCODE;
                        state_r <= S_ROM;
                     end else begin
                        step_r  <= STEP_UNFREEZE;
                        state_r <= S_SEND;
                     end
                  end
                  STEP_UCODE: begin
                     pc_r <= pc_inc;
                     if (pc_inc == len_r) begin
                        step_r  <= STEP_UNFREEZE;
                        state_r <= S_SEND;
                     end else begin
                        state_r <= S_ROM;
                     end
                  end
                  default: begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end
               endcase
            end
            S_ROM:   state_r <= S_RDATA;
            S_RDATA: begin
               data_r  <= rom_data_i;
               state_r <= S_SEND;
            end
            default: state_r <= S_DONE;
         endcase
      end
   end

   // Command fields come only from registers, so they hold steady while SEND waits for ready.
   always_comb begin
      cfg_addr = freeze_addr_lp;
      blk_data = '0;
      case (step_r)
         STEP_FREEZE: blk_data[0] = 1'b1;
         STEP_ICACHE: begin
            cfg_addr = icache_addr_lp;
            blk_data[cfg_data_width_p-1:0] = icache_mode_r;
         end
         STEP_DCACHE: begin
            cfg_addr = dcache_addr_lp;
            blk_data[cfg_data_width_p-1:0] = dcache_mode_r;
         end
         STEP_CCE: begin
            cfg_addr = cce_addr_lp;
            blk_data[cfg_data_width_p-1:0] = cce_mode_r;
         end
         STEP_UCODE: begin
            cfg_addr = ucode_base_lp + cfg_addr_width_p'(pc_r);
            blk_data[cce_instr_width_p-1:0] = data_r;
         end
         default: ;
      endcase
   end

   assign boot_cmd = {blk_data, cfg_base_addr_i | paddr_width_p'(cfg_addr), size_8_lp, uc_wr_lp};

   always_comb begin
      cfg_cmd_o        = '0;
      cfg_cmd_v_o      = 1'b0;
      cfg_resp_yumi_o  = 1'b0;
      host_cmd_ready_o = 1'b0;
      host_resp_o      = '0;
      host_resp_v_o    = 1'b0;
      rom_v_o          = 1'b0;
      rom_addr_o       = pc_r[cce_pc_width_p-1:0];
      case (state_r)
         S_SEND: begin
            cfg_cmd_o   = boot_cmd;
            cfg_cmd_v_o = 1'b1;
         end
         S_WAIT: cfg_resp_yumi_o = cfg_resp_v_i;
         S_ROM:  rom_v_o = 1'b1;
         S_DONE: begin
            cfg_cmd_o        = host_cmd_i;
            cfg_cmd_v_o      = host_cmd_v_i;
            host_cmd_ready_o = cfg_cmd_ready_i;
            host_resp_o      = cfg_resp_i;
            host_resp_v_o    = cfg_resp_v_i;
            cfg_resp_yumi_o  = host_resp_yumi_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bp_cfg_boot_seq.sv
// Bench for bp_cfg_boot_seq: endpoint/ROM model with a command scoreboard, boot timing,
// backpressure, passthrough and mid-boot reset scenarios.
`timescale 1ns/1ps
module tb_bp_cfg_boot_seq;

   localparam int PW  = 40;
   localparam int PCW = 4;
   localparam int IW  = 64;
   localparam int CAW = 16;
   localparam int CDW = 64;
   localparam int DW  = 64;
   localparam int W   = DW + PW + 7;

   localparam logic [PW-1:0] BASE     = 40'h12_3400_0000;
   localparam logic [15:0]   A_FREEZE = 16'h0008;
   localparam logic [15:0]   A_DID    = 16'h0014;
   localparam logic [15:0]   A_ICACHE = 16'h0024;
   localparam logic [15:0]   A_DCACHE = 16'h002c;
   localparam logic [15:0]   A_CCE    = 16'h0034;
   localparam logic [3:0]    T_UC_RD  = 4'd2;
   localparam logic [3:0]    T_UC_WR  = 4'd3;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic           start_i;
   logic [PW-1:0]  cfg_base_addr_i;
   logic [CDW-1:0] icache_mode_i, dcache_mode_i, cce_mode_i;
   logic [PCW:0]   ucode_len_i;
   logic           rom_v_o;
   logic [PCW-1:0] rom_addr_o;
   logic [IW-1:0]  rom_data_i = '0;
   logic [W-1:0]   cfg_cmd_o;
   logic           cfg_cmd_v_o;
   logic           cfg_cmd_ready_i;
   logic [W-1:0]   cfg_resp_i;
   logic           cfg_resp_v_i;
   logic           cfg_resp_yumi_o;
   logic [W-1:0]   host_cmd_i;
   logic           host_cmd_v_i;
   logic           host_cmd_ready_o;
   logic [W-1:0]   host_resp_o;
   logic           host_resp_v_o;
   logic           host_resp_yumi_i;
   logic           done_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0]   exp_q[$];
   logic [PCW-1:0] rom_q[$];
   logic [IW-1:0]  rom_mem [0:(1<<PCW)-1];
   bit             bp_mode;
   bit             pend;
   int             dly;
   int             cyc;
   int             n_acc;
   bit             held_v;
   logic [W-1:0]   held_cmd;

   bp_cfg_boot_seq #(
      .paddr_width_p(PW), .cce_pc_width_p(PCW), .cce_instr_width_p(IW),
      .cfg_addr_width_p(CAW), .cfg_data_width_p(CDW), .dword_width_p(DW)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
      .cfg_base_addr_i(cfg_base_addr_i),
      .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
      .ucode_len_i(ucode_len_i),
      .rom_v_o(rom_v_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
      .cfg_cmd_o(cfg_cmd_o), .cfg_cmd_v_o(cfg_cmd_v_o), .cfg_cmd_ready_i(cfg_cmd_ready_i),
      .cfg_resp_i(cfg_resp_i), .cfg_resp_v_i(cfg_resp_v_i), .cfg_resp_yumi_o(cfg_resp_yumi_o),
      .host_cmd_i(host_cmd_i), .host_cmd_v_i(host_cmd_v_i), .host_cmd_ready_o(host_cmd_ready_o),
      .host_resp_o(host_resp_o), .host_resp_v_o(host_resp_v_o), .host_resp_yumi_i(host_resp_yumi_i),
      .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous-read ROM: data appears the cycle after rom_v_o.
   always @(posedge clk_i) if (rom_v_o) rom_data_i <= rom_mem[rom_addr_o];

   function automatic logic [W-1:0] mk_cmd(input logic [3:0] t, input logic [15:0] a,
                                           input logic [DW-1:0] d);
      return {d, BASE | {{(PW-16){1'b0}}, a}, 3'b011, t};
   endfunction

   task automatic push_boot(input int len, input logic [CDW-1:0] im, dm, cm);
      exp_q.push_back(mk_cmd(T_UC_WR, A_FREEZE, 64'd1));
      exp_q.push_back(mk_cmd(T_UC_WR, A_ICACHE, im));
      exp_q.push_back(mk_cmd(T_UC_WR, A_DCACHE, dm));
      exp_q.push_back(mk_cmd(T_UC_WR, A_CCE, cm));
      for (int k = 0; k < len; k++) begin
         logic [15:0] ua;
         logic [PCW-1:0] ra;
         ua = 16'h8000 + 16'(k);
         ra = PCW'(k);
         exp_q.push_back(mk_cmd(T_UC_WR, ua, rom_mem[k]));
         rom_q.push_back(ra);
      end
      exp_q.push_back(mk_cmd(T_UC_WR, A_FREEZE, 64'd0));
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
      start_i = 1'b0;
      cfg_cmd_ready_i = 1'b0;
      cfg_resp_v_i = 1'b0;
      host_resp_yumi_i = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b0;
      exp_q.delete();
      rom_q.delete();
   endtask

   // Endpoint model for one cycle; called just after a falling edge.
   task automatic ep_cycle();
      logic [W-1:0]   e;
      logic [PCW-1:0] ea;
      cfg_cmd_ready_i = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pend && dly == 0) cfg_resp_v_i = 1'b1;
      else begin
         cfg_resp_v_i = 1'b0;
         if (pend) dly--;
      end
      cfg_resp_i = {W{1'b1}};
      #1;
      n_assert++;
      if (host_cmd_ready_o !== 1'b0 || host_resp_v_o !== 1'b0) begin
         n_fail++;
         $display("FAIL host_blocked cyc=%0d got ready=%b resp_v=%b want 0/0", cyc, host_cmd_ready_o, host_resp_v_o);
      end
      if (held_v) begin
         n_assert++;
         if (cfg_cmd_v_o !== 1'b1 || cfg_cmd_o !== held_cmd) begin
            n_fail++;
            $display("FAIL cmd_stable cyc=%0d got v=%b cmd=%h want v=1 cmd=%h", cyc, cfg_cmd_v_o, cfg_cmd_o, held_cmd);
         end
      end
      n_assert++;
      if (cfg_resp_yumi_o !== cfg_resp_v_i) begin
         n_fail++;
         $display("FAIL resp_yumi cyc=%0d got %b want %b", cyc, cfg_resp_yumi_o, cfg_resp_v_i);
      end
      if (cfg_resp_v_i) pend = 1'b0;
      if (rom_v_o === 1'b1) begin
         n_assert++;
         if (rom_q.size() == 0) begin
            n_fail++;
            $display("FAIL rom_extra cyc=%0d got addr=%0d want no read", cyc, rom_addr_o);
         end else begin
            ea = rom_q.pop_front();
            if (rom_addr_o !== ea) begin
               n_fail++;
               $display("FAIL rom_addr cyc=%0d got %0d want %0d", cyc, rom_addr_o, ea);
            end
         end
      end
      held_v   = (cfg_cmd_v_o === 1'b1) && !cfg_cmd_ready_i;
      held_cmd = cfg_cmd_o;
      if (cfg_cmd_v_o === 1'b1 && cfg_cmd_ready_i) begin
         n_assert++;
         if (pend) begin
            n_fail++;
            $display("FAIL outstanding cyc=%0d got 2 commands in flight want 1", cyc);
         end
         n_assert++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_extra cyc=%0d got %h want none", cyc, cfg_cmd_o);
         end else begin
            e = exp_q.pop_front();
            if (cfg_cmd_o !== e) begin
               n_fail++;
               $display("FAIL cmd cyc=%0d got %h want %h", cyc, cfg_cmd_o, e);
            end
         end
         pend  = 1'b1;
         dly   = bp_mode ? int'($urandom_range(0, 5)) : 0;
         n_acc++;
      end
   endtask

   // Runs a boot; done_cyc is the first cycle done_o is seen (start sampled in cycle 0),
   // -1 if the budget expires, -2 if stopped after abort_acc accepted commands.
   task automatic run_boot(input int len, input logic [CDW-1:0] im, dm, cm, input bit bp,
                           input int abort_acc, output int done_cyc);
      bp_mode = bp; pend = 1'b0; dly = 0; held_v = 1'b0; n_acc = 0;
      icache_mode_i = im; dcache_mode_i = dm; cce_mode_i = cm;
      ucode_len_i = len[PCW:0];
      push_boot(len, im, dm, cm);
      done_cyc = -1;
      @(negedge clk_i);
      cyc = 0;
      start_i = 1'b1;
      ep_cycle();
      while (cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         start_i = 1'b0;
         if (abort_acc > 0 && n_acc == abort_acc) begin
            done_cyc = -2;
            break;
         end
         if (done_o === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         ep_cycle();
      end
      cfg_resp_v_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; start_i = 1'b0; cfg_base_addr_i = BASE;
      icache_mode_i = '0; dcache_mode_i = '0; cce_mode_i = '0; ucode_len_i = '0;
      cfg_cmd_ready_i = 1'b1; cfg_resp_i = '0; cfg_resp_v_i = 1'b0;
      host_cmd_i = mk_cmd(T_UC_RD, A_DID, 64'd0); host_cmd_v_i = 1'b1; host_resp_yumi_i = 1'b0;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      repeat (20) @(negedge clk_i);
      n_assert++; if (cfg_cmd_v_o !== 1'b0) begin n_fail++; $display("FAIL idle_cmd_v got %b want 0", cfg_cmd_v_o); end
      n_assert++; if (cfg_resp_yumi_o !== 1'b0) begin n_fail++; $display("FAIL idle_yumi got %b want 0", cfg_resp_yumi_o); end
      n_assert++; if (rom_v_o !== 1'b0) begin n_fail++; $display("FAIL idle_rom_v got %b want 0", rom_v_o); end
      n_assert++; if (host_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL idle_host_ready got %b want 0", host_cmd_ready_o); end
      n_assert++; if (host_resp_v_o !== 1'b0) begin n_fail++; $display("FAIL idle_host_resp_v got %b want 0", host_resp_v_o); end
      n_assert++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL idle_done got %b want 0", done_o); end
   endtask

   task automatic test_boot_no_ucode();
      int dc;
      do_reset();
      run_boot(0, 64'd1, 64'd1, 64'd2, 1'b0, 0, dc);
      n_assert++; if (dc != 11) begin n_fail++; $display("FAIL noucode_done_cycle got %0d want 11", dc); end
      n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL noucode_drained got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_boot_ucode3();
      int dc;
      do_reset();
      for (int k = 0; k < (1<<PCW); k++) rom_mem[k] = 64'hA0 + 64'(k);
      run_boot(3, 64'd3, 64'd5, 64'd7, 1'b0, 0, dc);
      n_assert++; if (dc != 23) begin n_fail++; $display("FAIL ucode3_done_cycle got %0d want 23", dc); end
      n_assert++; if (exp_q.size() != 0 || rom_q.size() != 0) begin
         n_fail++; $display("FAIL ucode3_drained got %0d/%0d left want 0/0", exp_q.size(), rom_q.size()); end
   endtask

   task automatic test_backpressure();
      int dc;
      do_reset();
      for (int k = 0; k < (1<<PCW); k++) rom_mem[k] = {$urandom, $urandom};
      run_boot(5, 64'h11, 64'h22, 64'h33, 1'b1, 0, dc);
      n_assert++; if (dc < 31) begin n_fail++; $display("FAIL bp_done_cycle got %0d want >=31", dc); end
      n_assert++; if (exp_q.size() != 0 || rom_q.size() != 0) begin
         n_fail++; $display("FAIL bp_drained got %0d/%0d left want 0/0", exp_q.size(), rom_q.size()); end
   endtask

   task automatic test_full_ucode();
      int dc;
      do_reset();
      for (int k = 0; k < (1<<PCW); k++) rom_mem[k] = {$urandom, $urandom};
      run_boot(1<<PCW, 64'h4, 64'h5, 64'h6, 1'b0, 0, dc);
      n_assert++; if (dc != 11 + 4*(1<<PCW)) begin
         n_fail++; $display("FAIL full_done_cycle got %0d want %0d", dc, 11 + 4*(1<<PCW)); end
      n_assert++; if (exp_q.size() != 0 || rom_q.size() != 0) begin
         n_fail++; $display("FAIL full_drained got %0d/%0d left want 0/0", exp_q.size(), rom_q.size()); end
   endtask

   task automatic test_passthrough();
      logic [W-1:0] hc, rsp;
      hc  = mk_cmd(T_UC_RD, A_DID, 64'd0);
      rsp = mk_cmd(T_UC_RD, A_DID, 64'h42);
      @(negedge clk_i);
      host_cmd_i = hc; host_cmd_v_i = 1'b1; cfg_cmd_ready_i = 1'b0;
      #1;
      n_assert++; if (cfg_cmd_o !== hc || cfg_cmd_v_o !== 1'b1) begin
         n_fail++; $display("FAIL pt_cmd got v=%b %h want v=1 %h", cfg_cmd_v_o, cfg_cmd_o, hc); end
      n_assert++; if (host_cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL pt_ready_low got %b want 0", host_cmd_ready_o); end
      cfg_cmd_ready_i = 1'b1;
      #1;
      n_assert++; if (host_cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL pt_ready_high got %b want 1", host_cmd_ready_o); end
      @(negedge clk_i);
      host_cmd_v_i = 1'b0; cfg_resp_i = rsp; cfg_resp_v_i = 1'b1; host_resp_yumi_i = 1'b0;
      #1;
      n_assert++; if (host_resp_v_o !== 1'b1 || host_resp_o !== rsp) begin
         n_fail++; $display("FAIL pt_resp got v=%b %h want v=1 %h", host_resp_v_o, host_resp_o, rsp); end
      n_assert++; if (cfg_resp_yumi_o !== 1'b0) begin n_fail++; $display("FAIL pt_yumi_low got %b want 0", cfg_resp_yumi_o); end
      n_assert++; if (cfg_cmd_v_o !== 1'b0) begin n_fail++; $display("FAIL pt_cmd_idle got %b want 0", cfg_cmd_v_o); end
      host_resp_yumi_i = 1'b1;
      #1;
      n_assert++; if (cfg_resp_yumi_o !== 1'b1) begin n_fail++; $display("FAIL pt_yumi_high got %b want 1", cfg_resp_yumi_o); end
      @(negedge clk_i);
      cfg_resp_v_i = 1'b0; host_resp_yumi_i = 1'b0;
      repeat (5) @(negedge clk_i);
      n_assert++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL done_sticky got %b want 1", done_o); end
   endtask

   task automatic test_reset_mid_ucode();
      int dc;
      do_reset();
      host_cmd_v_i = 1'b1;
      for (int k = 0; k < (1<<PCW); k++) rom_mem[k] = 64'hB0 + 64'(k);
      run_boot(3, 64'd1, 64'd2, 64'd3, 1'b0, 6, dc);
      n_assert++; if (dc != -2) begin n_fail++; $display("FAIL mid_reached_wait got %0d want -2", dc); end
      reset_i = 1'b1; cfg_resp_v_i = 1'b1;
      #1;
      n_assert++; if (cfg_cmd_v_o !== 1'b0 || rom_v_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_outs got cmd_v=%b rom_v=%b done=%b want 0/0/0", cfg_cmd_v_o, rom_v_o, done_o); end
      n_assert++; if (cfg_resp_yumi_o !== 1'b0 || host_cmd_ready_o !== 1'b0 || host_resp_v_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_hs got yumi=%b hready=%b hresp_v=%b want 0/0/0", cfg_resp_yumi_o, host_cmd_ready_o, host_resp_v_o); end
      exp_q.delete(); rom_q.delete();
      @(negedge clk_i);
      reset_i = 1'b0; cfg_resp_v_i = 1'b0;
      run_boot(3, 64'd1, 64'd2, 64'd3, 1'b0, 0, dc);
      n_assert++; if (dc != 23) begin n_fail++; $display("FAIL reboot_done_cycle got %0d want 23", dc); end
      n_assert++; if (exp_q.size() != 0 || rom_q.size() != 0) begin
         n_fail++; $display("FAIL reboot_drained got %0d/%0d left want 0/0", exp_q.size(), rom_q.size()); end
   endtask

   initial begin
      for (int k = 0; k < (1<<PCW); k++) rom_mem[k] = '0;
      test_reset();
      test_boot_no_ucode();
      test_boot_ucode3();
      test_backpressure();
      test_full_ucode();
      test_passthrough();
      test_reset_mid_ucode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
